// File: rtl/updown_counter_param.sv
// Parametrised modulo-N up/down counter with load, enable, wrap/saturate
// boundary policy, terminal-count pulse and sticky overflow/underflow flags.
module updown_counter_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MOD_MAX  = 2**WIDTH-1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    if (MOD_MAX < 1 || MOD_MAX > 2**WIDTH-1) begin : g_bad_mod_max
        $error("updown_counter_param: MOD_MAX out of range 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MOD_MAX);
    localparam logic [WIDTH-1:0] ZeroVal = '0;
    localparam logic [WIDTH-1:0] OneVal  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic at_max;
    logic at_zero;

    assign at_max  = (count_q == MaxVal);
    assign at_zero = (count_q == ZeroVal);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        // A boundary event below overrides this clear, so set wins
        ovf_d   = ovf_q & ~clr_flags;
        unf_d   = unf_q & ~clr_flags;

        if (load) begin
            count_d = (load_val > MaxVal) ? MaxVal : load_val;
        end else if (en) begin
            if (mode) begin
                if (at_max) begin
                    count_d = SATURATE ? MaxVal : ZeroVal;
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + OneVal;
                end
            end else begin
                if (at_zero) begin
                    count_d = SATURATE ? ZeroVal : MaxVal;
                    tc_d    = 1'b1;
                    unf_d   = 1'b1;
                end else begin
                    count_d = count_q - OneVal;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule
